// File: rtl/wb_queue_if.sv
// Write-back queue bus: two result sources, register-file write port,
// forwarding lookup and occupancy status. The slave modport is the queue.
interface wb_queue_if #(
   parameter int unsigned DEPTH = 4
);
   // load-result source
   logic                    memValid;
   logic                    memReady;
   logic [4:0]              memReg;
   logic [31:0]             memData;
   // ALU-result source
   logic                    aluValid;
   logic                    aluReady;
   logic [4:0]              aluReg;
   logic [31:0]             aluData;
   // register-file write port
   logic                    regWrite;
   logic [4:0]              writeReg;
   logic [31:0]             writeData;
   // forwarding lookup
   logic [4:0]              readReg1;
   logic [4:0]              readReg2;
   logic                    fwdHit1;
   logic [31:0]             fwdData1;
   logic                    fwdHit2;
   logic [31:0]             fwdData2;
   // occupancy
   logic [$clog2(DEPTH):0]  count;
   logic                    full;
   logic                    empty;

   modport slave (
      input  memValid, memReg, memData, aluValid, aluReg, aluData, readReg1, readReg2,
      output memReady, aluReady, regWrite, writeReg, writeData,
      output fwdHit1, fwdData1, fwdHit2, fwdData2, count, full, empty
   );

   modport master (
      output memValid, memReg, memData, aluValid, aluReg, aluData, readReg1, readReg2,
      input  memReady, aluReady, regWrite, writeReg, writeData,
      input  fwdHit1, fwdData1, fwdHit2, fwdData2, count, full, empty
   );
endinterface

// File: rtl/wb_queue.sv
// Write-back queue: circular FIFO of {reg, data} results from the load and
// ALU paths, drained one entry per cycle into the register file.
// Optional forwarding lookup enabled by defining WB_QUEUE_FWD_EN.
module wb_queue #(
   parameter int unsigned DEPTH = 4
) (
   input logic       clk,
   input logic       rst,
   wb_queue_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0] head_q;
   logic [AW-1:0] tail_q;
   logic [CW-1:0] count_q;
   logic [4:0]    reg_q  [DEPTH];
   logic [31:0]   data_q [DEPTH];

   logic        full;
   logic        empty;
   logic        mem_fire;
   logic        alu_fire;
   logic        push;
   logic        pop;
   logic [4:0]  push_reg;
   logic [31:0] push_data;

   // Ready depends only on registered full, so a pop cycle never frees a slot early
   always_comb begin
      full      = (count_q == CW'(DEPTH));
      empty     = (count_q == '0);
      mem_fire  = bus.memValid && !full;
      alu_fire  = bus.aluValid && !full && !bus.memValid;
      push_reg  = bus.memValid ? bus.memReg : bus.aluReg;
      push_data = bus.memValid ? bus.memData : bus.aluData;
      // r0 results complete the handshake but are dropped
      push      = (mem_fire || alu_fire) && (push_reg != 5'd0);
      pop       = !empty;
   end

   // Status, handshake and write-port outputs
   always_comb begin
      bus.full      = full;
      bus.empty     = empty;
      bus.count     = count_q;
      bus.memReady  = !full;
      bus.aluReady  = !full && !bus.memValid;
      bus.regWrite  = !empty;
      bus.writeReg  = empty ? 5'd0 : reg_q[head_q];
      bus.writeData = empty ? 32'd0 : data_q[head_q];
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; contents beyond count are never observed, so no reset
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         reg_q[tail_q]  <= push_reg;
         data_q[tail_q] <= push_data;
      end
   end

`ifdef WB_QUEUE_FWD_EN
   // Scan oldest to youngest so the youngest match wins
   always_comb begin
      logic [AW-1:0] idx;
      bus.fwdHit1  = 1'b0;
      bus.fwdData1 = 32'd0;
      bus.fwdHit2  = 1'b0;
      bus.fwdData2 = 32'd0;
      idx          = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + AW'(i);
         if (CW'(i) < count_q) begin
            if (bus.readReg1 != 5'd0 && reg_q[idx] == bus.readReg1) begin
               bus.fwdHit1  = 1'b1;
               bus.fwdData1 = data_q[idx];
            end
            if (bus.readReg2 != 5'd0 && reg_q[idx] == bus.readReg2) begin
               bus.fwdHit2  = 1'b1;
               bus.fwdData2 = data_q[idx];
            end
         end
      end
   end
`else
   logic unused_fwd;

   // Forwarding disabled: outputs tied off, lookup addresses ignored
   always_comb begin
      unused_fwd   = ^{bus.readReg1, bus.readReg2};
      bus.fwdHit1  = 1'b0;
      bus.fwdData1 = 32'd0;
      bus.fwdHit2  = 1'b0;
      bus.fwdData2 = 32'd0;
   end
`endif
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending write-back entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports memValid/memReady  input/output  1/1  load-result handshake.
REQ-005 SHALL have ports memReg/memData  input  5/32  load destination register and value.
REQ-006 SHALL have ports aluValid/aluReady  input/output  1/1  ALU-result handshake.
REQ-007 SHALL have ports aluReg/aluData  input  5/32  ALU destination register and value.
REQ-008 SHALL have ports regWrite/writeReg/writeData  output  1/5/32  register-file write port.
REQ-009 SHALL have ports readReg1/readReg2  input  5/5  register-file read addresses, for forwarding lookup.
REQ-010 SHALL have ports fwdHit1/fwdData1, fwdHit2/fwdData2  output  1/32 each  forwarding results.
REQ-011 SHALL have ports count/full/empty  output  log2(DEPTH)+1/1/1  occupancy status.

Function
REQ-012 SHALL hold a circular FIFO of DEPTH {reg[4:0], data[31:0]} entries with head/tail pointers that wrap modulo DEPTH.
REQ-013 SHALL transfer on a source only when its valid and ready are both high at a rising clk edge.
REQ-014 SHALL accept at most one result per cycle; mem has priority: memReady = !full, aluReady = !full && !memValid.
REQ-015 SHALL compute ready from the registered full flag only, so no enqueue occurs while full, even in a pop cycle.
REQ-016 SHALL accept a result whose reg is 0 (handshake completes) but SHALL NOT store it; count is unchanged.
REQ-017 SHALL drive regWrite = !empty, with writeReg/writeData = head entry, combinationally from registered state.
REQ-018 SHALL pop the head on every edge where regWrite is high; the register file has no backpressure.
REQ-019 SHALL give a latency of one cycle: a result accepted at edge N appears on the write port during cycle N+1 (queue empty beforehand).
REQ-020 SHALL handle simultaneous push and pop so that count is unchanged and both pointers advance.
REQ-021 SHALL keep count in 0..DEPTH, with full = (count==DEPTH) and empty = (count==0).
REQ-022 SHALL write back entries in acceptance order; two pending writes to the same register both reach the port, oldest first.

Reset
REQ-023 SHALL, when rst is high at an edge, clear head, tail and count to 0, which makes regWrite 0, empty 1, full 0, memReady 1 and aluReady = !memValid.
REQ-024 SHALL drive writeReg and writeData to 0 while empty.
REQ-025 SHALL, on reset mid-operation, discard all pending entries; no write of a discarded entry reaches the port, and inputs are ignored on the reset edge.

Configuration
REQ-026 SHALL, with WB_QUEUE_FWD_EN defined, set fwdHitN = 1 when readRegN != 0 matches any valid entry, and set fwdDataN to the youngest matching entry's data; this is combinational.
REQ-027 SHALL, with WB_QUEUE_FWD_EN undefined, tie fwdHit1/2 and fwdData1/2 to 0 and omit the comparators; the ports remain present.

Verification
REQ-028 SHALL verify: aluValid=1, aluReg=5, aluData=0xDEADBEEF for one cycle into an empty queue -> next cycle regWrite=1, writeReg=5, writeData=0xDEADBEEF; the cycle after, empty=1.
REQ-029 SHALL verify: memValid=1 (reg 3, 0x11) and aluValid=1 (reg 4, 0x22) in the same cycle -> mem accepted, aluReady=0; alu accepted the next cycle; writes occur in order r3 then r4.
REQ-030 SHALL verify: memValid held with DEPTH=4, regWrite pops concurrent -> count never exceeds 4; sustained throughput of 1 entry/cycle; the write stream equals the input stream across pointer wrap (>=10 entries).
REQ-031 SHALL verify: aluReg=0, aluData=0x55 accepted -> aluReady=1, count stays 0, regWrite stays 0.
REQ-032 SHALL verify, with WB_QUEUE_FWD_EN defined: pending r7=0x1 then r7=0x2, readReg1=7 -> fwdHit1=1, fwdData1=0x2; readReg2=0 -> fwdHit2=0. With it undefined, all forwarding outputs are 0.
REQ-033 SHALL verify: 3 entries pending, then rst=1 for one edge -> count=0, regWrite=0 after the edge; no pending entry is ever written.
